// File: rtl/speed_meas_pkg.sv
// Shared definitions for the speed measurement controller: parameter
// defaults, controller state encoding and a small width helper.
package speed_meas_pkg;

    localparam int N_DEF        = 20;
    localparam int PRESCALE_DEF = 1000;
    localparam int K_DEF        = 14400;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        PUBLISH
    } state_e;

    // Counter width for a modulus, never below one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser for the raw sensor pulse followed by a registered
// rising-edge detector; the edge pulse appears three clocks after the input rises.
module pulse_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic pulse_i,
    output logic edge_o
);

    // [0],[1] are the synchroniser stages, [2] holds the previous synced level.
    logic [2:0] sync_q;
    logic       edge_q;

    // Shift the pulse through the synchroniser and register the rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], pulse_i};
            edge_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/speed_meas_ctrl.sv
// Measures the period between sensor edges in prescaled ticks and drives an
// external divider to turn it into speed = K / period.  A missing edge for
// TIMEOUT_TICKS reports speed 0 once and waits for a fresh arming edge.
module speed_meas_ctrl
    import speed_meas_pkg::*;
#(
    parameter int N             = N_DEF,
    parameter int PRESCALE      = PRESCALE_DEF,
    parameter int K             = K_DEF,
    parameter int TIMEOUT_TICKS = (1 << N) - 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pulse_in,
    output logic [N-1:0] dividend,
    output logic [N-1:0] divisor,
    output logic         sen1,
    output logic         sen2,
    input  logic [N-1:0] div_q,
    input  logic         div_done,
    output logic [N-1:0] speed,
    output logic         speed_valid,
    output logic         overrun
);

    localparam int           PW       = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [N-1:0]  TO_LIM   = N'(TIMEOUT_TICKS);

    logic          edge_pulse;
    logic [PW-1:0] pre_q;
    logic [N-1:0]  cnt_q, period_q, divisor_q, speed_q;
    logic          armed_q, pending_q, to_pend_q, overrun_q;
    logic          sen1_q, sen2_q, valid_q, done_prev_q, fresh_q;
    state_e        state_q;

    logic          tick, timeout_hit, take_period, take_timeout, done_rise;
    logic [N-1:0]  cnt_d, period_d;

    pulse_sync_edge u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pulse_i (pulse_in),
        .edge_o  (edge_pulse)
    );

    // A tick landing on the same clock as an edge still belongs to the period
    // that edge closes, so the latched value uses the incremented count.
    assign tick         = (pre_q == PRE_LAST);
    assign cnt_d        = (tick && cnt_q != TO_LIM) ? cnt_q + N'(1) : cnt_q;
    assign period_d     = (cnt_d == '0) ? N'(1) : cnt_d;
    assign timeout_hit  = armed_q && !edge_pulse && (cnt_d == TO_LIM);
    assign take_period  = (state_q == IDLE) && pending_q;
    assign take_timeout = (state_q == IDLE) && !pending_q && to_pend_q;
    assign done_rise    = div_done && !done_prev_q;

    // Prescaler, tick counter, arming, period capture and overrun tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q     <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            armed_q   <= 1'b0;
            pending_q <= 1'b0;
            to_pend_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (take_timeout) to_pend_q <= 1'b0;
            if (edge_pulse) begin
                pre_q   <= '0;
                cnt_q   <= '0;
                armed_q <= 1'b1;
                if (armed_q) begin
                    period_q  <= period_d;
                    pending_q <= 1'b1;
                    // Only a period the FSM is not taking right now is lost.
                    if (pending_q && !take_period) overrun_q <= 1'b1;
                end
            end else begin
                pre_q <= tick ? '0 : pre_q + PW'(1);
                if (take_period) pending_q <= 1'b0;
                if (timeout_hit) begin
                    cnt_q     <= '0;
                    armed_q   <= 1'b0;
                    to_pend_q <= 1'b1;
                end else if (armed_q) begin
                    cnt_q <= cnt_d;
                end
            end
        end
    end

    // Divider handshake FSM with registered outputs; a pending period takes
    // precedence over a deferred timeout since it was captured earlier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            divisor_q   <= '0;
            speed_q     <= '0;
            sen1_q      <= 1'b0;
            sen2_q      <= 1'b0;
            valid_q     <= 1'b0;
            done_prev_q <= 1'b0;
            fresh_q     <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            done_prev_q <= div_done;
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        divisor_q <= period_q;
                        sen1_q    <= 1'b1;
                        state_q   <= LOAD;
                    end else if (to_pend_q) begin
                        speed_q <= '0;
                        valid_q <= 1'b1;
                    end
                end
                LOAD: begin
                    fresh_q <= 1'b0;
                    sen2_q  <= 1'b1;
                    state_q <= START;
                end
                START: begin
                    if (done_rise) fresh_q <= 1'b1;
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A done level left over from the previous divide is ignored.
                    if (done_rise || fresh_q) begin
                        sen1_q  <= 1'b0;
                        sen2_q  <= 1'b0;
                        state_q <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    speed_q <= div_q;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dividend    = N'(K);
    assign divisor     = divisor_q;
    assign sen1        = sen1_q;
    assign sen2        = sen2_q;
    assign speed       = speed_q;
    assign speed_valid = valid_q;
    assign overrun     = overrun_q;

endmodule
